vec_mem_ctrl: RTL and testbench

VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

---
 rtl/vmem_pkg.sv | 25 ++
 rtl/vmem_ram.sv | 33 +++
 rtl/vec_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vec_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared definitions for the vector memory controller: default geometry
// (LANES, DATA_W, ADDR_W, DEPTH), the lane-vector type and the FSM state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package vmem_pkg;

    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BEAT_W = $clog2(LANES);

    // Lane i lives at bits [i*DATA_W +: DATA_W]; vector beat b maps to lane LANES-1-b.
    typedef logic [LANES-1:0][DATA_W-1:0] laneVec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } vmemState_t;

endpackage

// File: rtl/vmem_ram.sv
// -----------------------------------------------------------------------------
// vmem_ram
// Single-port DEPTH x DATA_W storage. Synchronous write, registered read with
// one cycle of latency (read-before-write on a same-address access). No reset:
// contents survive controller resets.
// Ports:
//   clk     rising-edge clock
//   we      write enable
//   addr    word address
//   wrData  write word
//   rdData  registered read word (valid the cycle after addr is presented)
// -----------------------------------------------------------------------------
module vmem_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wrData;
        end
        rdData <= mem[addr];
    end

endmodule

// File: rtl/vec_mem_ctrl.sv
// -----------------------------------------------------------------------------
// vec_mem_ctrl
// Vector/scalar memory controller. One request is accepted in IDLE; it is then
// carried out as 1 (scalar) or LANES (vector) single-word RAM beats. Reads pass
// through a capture stage and publish the whole lane vector at completion.
//
// Optional feature (macro VMEM_BOUNDS_CHK_EN): a vector request whose span
// would run past the end of memory is rejected with err+done one cycle after
// acceptance and no RAM access. Without the macro addresses wrap modulo DEPTH
// and err stays low.
//
// Handshake: req is only looked at while busy=0 (IDLE); a request seen there
// is accepted on that clock edge, and anything on req while busy=1 is dropped,
// never queued. done pulses for exactly one cycle per accepted request and
// data_read is valid from that cycle until the next read completes.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req         request strobe
//   addr        base word address
//   mem_write   1 = write, 0 = read
//   vec_scalar  1 = vector (LANES words), 0 = scalar (one word, top lane)
//   data_write  lane-vector write data
//   data_read   lane-vector read data
//   busy        high whenever not IDLE
//   done        one-cycle completion pulse
//   err         one-cycle bounds-error pulse
//   dbgState    current FSM state (vmem_pkg::vmemState_t encoding)
// -----------------------------------------------------------------------------
module vec_mem_ctrl #(
    parameter int LANES  = vmem_pkg::LANES,
    parameter int DATA_W = vmem_pkg::DATA_W,
    parameter int ADDR_W = vmem_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         mem_write,
    input  logic                         vec_scalar,
    input  logic [LANES-1:0][DATA_W-1:0] data_write,
    output logic [LANES-1:0][DATA_W-1:0] data_read,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   dbgState
);

    import vmem_pkg::*;

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int BW        = (LANES > 1) ? $clog2(LANES) : 1;

    vmemState_t                   state;
    logic [BW-1:0]                beat;
    logic [ADDR_W-1:0]            addrLat;
    logic                         writeLat;
    logic                         vecLat;
    logic [LANES-1:0][DATA_W-1:0] dataLat;
    logic [LANES-1:0][DATA_W-1:0] rdBuf;
    logic [LANES-1:0][DATA_W-1:0] dataRead;
    logic                         busyQ;
    logic                         doneQ;
    logic                         errQ;

    logic                         oob;
    logic                         isLast;
    logic [BW-1:0]                laneIdx;
    logic [BW-1:0]                prevLane;
    logic                         ramWe;
    logic [ADDR_W-1:0]            ramAddr;
    logic [DATA_W-1:0]            ramRdata;

`ifdef VMEM_BOUNDS_CHK_EN
    assign oob = vec_scalar && (addr > ADDR_W'(MEM_DEPTH - LANES));
`else
    assign oob = 1'b0;
`endif

    assign isLast   = (beat == (vecLat ? BW'(LANES - 1) : '0));
    assign laneIdx  = BW'(LANES - 1) - beat;
    // Lane of the previous beat, whose RAM data is arriving this cycle.
    assign prevLane = laneIdx + 1'b1;

    // Address wraps naturally in ADDR_W bits.
    assign ramAddr  = addrLat + ADDR_W'(beat);
    assign ramWe    = (state == XFER) && writeLat;

    vmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uRam (
        .clk    (clk),
        .we     (ramWe),
        .addr   (ramAddr),
        .wrData (dataLat[laneIdx]),
        .rdData (ramRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat     <= '0;
            addrLat  <= '0;
            writeLat <= 1'b0;
            vecLat   <= 1'b0;
            dataLat  <= '0;
            rdBuf    <= '0;
            dataRead <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addrLat  <= addr;
                        writeLat <= mem_write;
                        vecLat   <= vec_scalar;
                        dataLat  <= data_write;
                        beat     <= '0;
                        // Cleared so a scalar read publishes zeros in the unused lanes.
                        rdBuf    <= '0;
                        busyQ    <= 1'b1;
                        if (oob) begin
                            state <= DONE;
                            doneQ <= 1'b1;
                            errQ  <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!writeLat && (beat != '0)) begin
                        rdBuf[prevLane] <= ramRdata;
                    end
                    if (isLast) begin
                        if (writeLat) begin
                            state <= DONE;
                            doneQ <= 1'b1;
                        end else begin
                            state <= CAP;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                CAP: begin
                    // Last beat's data merges straight into the published vector.
                    dataRead          <= rdBuf;
                    dataRead[laneIdx] <= ramRdata;
                    state             <= DONE;
                    doneQ             <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    beat  <= '0;
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                    errQ  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_read = dataRead;
    assign busy      = busyQ;
    assign done      = doneQ;
    assign err       = errQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vec_mem_ctrl
// Self-checking bench for vec_mem_ctrl. A reference memory array and the last
// published read vector are kept here and updated from the request semantics
// (beat b of a vector touches word (addr+b) mod DEPTH and lane LANES-1-b).
// Optional macro VMEM_BOUNDS_CHK_EN selects the bounds-rejection expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vec_mem_ctrl;

    import vmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              mem_write;
    logic              vec_scalar;
    laneVec_t          data_write;
    laneVec_t          data_read;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbgState;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vec_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr       (addr),
        .mem_write  (mem_write),
        .vec_scalar (vec_scalar),
        .data_write (data_write),
        .data_read  (data_read),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbgState   (dbgState)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] refMem [DEPTH];
    laneVec_t          refRead;
    int                testsRun    = 0;
    int                testsFailed = 0;

    task automatic check(input string tag, input logic [LANES*DATA_W-1:0] obs,
                         input logic [LANES*DATA_W-1:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic laneVec_t randVec();
        laneVec_t v;
        for (int i = 0; i < LANES; i++) v[i] = $urandom;
        return v;
    endfunction

    function automatic void modelWrite(input logic [ADDR_W-1:0] a, input logic vec, input laneVec_t d);
        if (vec) begin
            for (int b = 0; b < LANES; b++) refMem[(int'(a) + b) % DEPTH] = d[LANES-1-b];
        end else begin
            refMem[a] = d[LANES-1];
        end
    endfunction

    function automatic laneVec_t modelRead(input logic [ADDR_W-1:0] a, input logic vec);
        laneVec_t v = '0;
        if (vec) begin
            for (int b = 0; b < LANES; b++) v[LANES-1-b] = refMem[(int'(a) + b) % DEPTH];
        end else begin
            v[LANES-1] = refMem[a];
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    // Issues one request, watches 24 cycles, and checks latency, pulse counts
    // and the published read vector against the model.
    task automatic runReq(input string tag, input logic wr, input logic vec,
                          input logic [ADDR_W-1:0] a, input laneVec_t d);
        int       doneAt  = 0;
        int       doneCnt = 0;
        int       busyCnt = 0;
        int       errCnt  = 0;
        int       expLat;
        bit       oobExp  = 1'b0;
        laneVec_t atDone  = '0;
`ifdef VMEM_BOUNDS_CHK_EN
        oobExp = vec && (int'(a) > DEPTH - LANES);
`endif
        expLat = oobExp ? 1 : ((vec ? LANES : 1) + (wr ? 1 : 2));
        @(negedge clk);
        req = 1'b1; mem_write = wr; vec_scalar = vec; addr = a; data_write = d;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance: the DUT must work from latched values.
        req = 1'b0; addr = ADDR_W'($urandom); data_write = randVec();
        mem_write = ~wr; vec_scalar = ~vec;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (err) errCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = k;
                    atDone = data_read;
                end
            end
        end
        if (!oobExp) begin
            if (wr) modelWrite(a, vec, d);
            else refRead = modelRead(a, vec);
        end
        check({tag, "_latency"}, doneAt, expLat);
        check({tag, "_done_pulses"}, doneCnt, 1);
        check({tag, "_busy_cycles"}, busyCnt, expLat);
        check({tag, "_err_pulses"}, errCnt, oobExp ? 1 : 0);
        check({tag, "_data_at_done"}, atDone, refRead);
        check({tag, "_data_held"}, data_read, refRead);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        laneVec_t d;
        laneVec_t e;
        int       heldDone;
        int       heldIdle;
        int       drainDone;
        int       badData;
        int       period;
        int       expHeld;
        int       expAcc;

        rst = 1'b0; req = 1'b0; addr = '0; mem_write = 1'b0; vec_scalar = 1'b0;
        data_write = '0; refRead = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_data", data_read, 0);
        check("reset_state", dbgState, 0);
        rst = 1'b1;

        // Prefill the regions later reads use (RAM itself has no reset).
        runReq("fill_1fe0", 1'b1, 1'b1, 13'h1FE0, randVec());
        runReq("fill_1ff0", 1'b1, 1'b1, 13'h1FF0, randVec());
        runReq("fill_0000", 1'b1, 1'b1, 13'h0000, randVec());
        runReq("fill_0010", 1'b1, 1'b1, 13'h0010, randVec());
        runReq("fill_0020", 1'b1, 1'b1, 13'h0020, randVec());
        runReq("fill_0030", 1'b1, 1'b1, 13'h0030, randVec());
        runReq("fill_0200", 1'b1, 1'b1, 13'h0200, randVec());

        // Scalar write/read round trip at 0x010.
        d = randVec();
        d[LANES-1] = 32'hDEADBEEF;
        runReq("scalar_wr", 1'b1, 1'b0, 13'h0010, d);
        runReq("scalar_rd", 1'b0, 1'b0, 13'h0010, randVec());
        e = '0;
        e[LANES-1] = 32'hDEADBEEF;
        check("scalar_rd_const", data_read, e);

        // Vector write/read at 0x100 with lane i = 0x1000+i.
        for (int i = 0; i < LANES; i++) d[i] = 32'h1000 + i;
        runReq("vec_wr", 1'b1, 1'b1, 13'h0100, d);
        runReq("vec_rd", 1'b0, 1'b1, 13'h0100, randVec());
        check("vec_rd_const", data_read, d);
        runReq("scalar_rd_10f", 1'b0, 1'b0, 13'h010F, randVec());
        e = '0;
        e[LANES-1] = 32'h1000;
        check("scalar_rd_10f_const", data_read, e);

        // Vector read crossing the top of memory (rejected when bounds checking is on).
        runReq("vec_rd_1ff8", 1'b0, 1'b1, 13'h1FF8, randVec());

        // req held high for 40 cycles during vector reads of 0x100.
        e = modelRead(13'h0100, 1'b1);
        @(negedge clk);
        req = 1'b1; mem_write = 1'b0; vec_scalar = 1'b1; addr = 13'h0100;
        heldDone = 0; heldIdle = 0; drainDone = 0; badData = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!busy) heldIdle++;
            if (done) begin
                heldDone++;
                if (data_read !== e) badData++;
            end
            if (k == 40) req = 1'b0;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                drainDone++;
                if (data_read !== e) badData++;
            end
        end
        // Each request: LANES+2 busy cycles then one IDLE cycle where the next is accepted.
        period  = LANES + 3;
        expAcc  = (40 - 1) / period + 1;
        expHeld = 0;
        for (int a = 0; a < expAcc; a++) if (a * period + LANES + 2 <= 40) expHeld++;
        check("held_done_window", heldDone, expHeld);
        check("held_idle_cycles", heldIdle, expAcc - 1);
        check("held_done_total", heldDone + drainDone, expAcc);
        check("held_data_bad", badData, 0);
        refRead = e;

        // Reset during beat 5 of a vector write to 0x200.
        d = randVec();
        @(negedge clk);
        req = 1'b1; mem_write = 1'b1; vec_scalar = 1'b1; addr = 13'h0200; data_write = d;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_data", data_read, 0);
        check("abort_state", dbgState, 0);
        for (int b = 0; b < 5; b++) refMem[13'h0200 + b] = d[LANES-1-b];
        refRead = '0;
        @(negedge clk);
        rst = 1'b1;
        runReq("abort_readback", 1'b0, 1'b1, 13'h0200, randVec());

        // Random traffic inside the prefilled window around address 0.
        for (int t = 0; t < 25; t++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'(13'h1FE0 + $urandom_range(0, 48));
            runReq($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ra, randVec());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
